// File: rtl/ds8dac_mix_sched.sv
// Sample-rate scheduler and voice mixer feeding the 8-bit delta-sigma DAC.
// Polls voices in fixed order each sample period, scales the mix and slew-limits the DAC code.
module ds8dac_mix_sched #(
    parameter int unsigned NUM_VOICES = 4,
    parameter int unsigned CLK_DIV    = 256,
    parameter int unsigned RAMP_STEP  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_VOICES-1:0]   voice_valid,
    input  logic [8*NUM_VOICES-1:0] voice_data,
    output logic [NUM_VOICES-1:0]   voice_ready,
    input  logic [7:0]              master_vol,
    input  logic                    enable,
    input  logic                    underrun_clr,
    output logic [7:0]              dac_code,
    output logic                    sample_tick,
    output logic [NUM_VOICES-1:0]   underrun
);

    localparam int unsigned NV   = NUM_VOICES;
    localparam int unsigned LOG2 = $clog2(NUM_VOICES);
    localparam int unsigned AW   = 8 + LOG2;
    localparam int unsigned IW   = LOG2;
    localparam int unsigned DW   = $clog2(CLK_DIV);
    localparam logic signed [9:0] STEP = 10'(RAMP_STEP);

    typedef enum logic [1:0] {IDLE, COLLECT, SCALE, SLEW} state_t;

    state_t                 state, state_nxt;
    logic [DW-1:0]          div_cnt;
    logic [IW-1:0]          idx, idx_nxt;
    logic signed [AW-1:0]   acc, acc_nxt;
    logic signed [7:0]      scaled, scaled_nxt;
    logic [7:0]             dac_nxt;
    logic [NV-1:0]          ready_nxt;
    logic [NV-1:0]          set_mask;
    logic [NV-1:0]          underrun_nxt;
    logic                   tick_nxt;

    logic signed [7:0]      sample;
    logic signed [7:0]      avg;
    logic signed [16:0]     prod;
    logic [7:0]             target;
    logic signed [9:0]      diff;

    // Mix datapath: selected sample, floor average, signed x unsigned gain, slew target.
    assign sample = voice_data[{idx, 3'b000} +: 8];
    assign avg    = 8'(acc >>> LOG2);
    assign prod   = 17'(avg) * $signed(17'({1'b0, master_vol}));
    assign target = enable ? {~scaled[7], scaled[6:0]} : 8'd128;
    assign diff   = $signed({2'b00, target}) - $signed({2'b00, dac_code});

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        acc_nxt    = acc;
        scaled_nxt = scaled;
        dac_nxt    = dac_code;
        ready_nxt  = '0;
        tick_nxt   = 1'b0;
        set_mask   = '0;
        case (state)
            IDLE: begin
                if (div_cnt == '0) begin
                    state_nxt = COLLECT;
                    idx_nxt   = '0;
                    acc_nxt   = '0;
                    tick_nxt  = 1'b1;
                    ready_nxt = NV'(1);
                end
            end
            COLLECT: begin
                if (voice_valid[idx]) begin
                    acc_nxt = acc + {{LOG2{sample[7]}}, sample};
                end else begin
                    set_mask[idx] = 1'b1;
                end
                if (idx == IW'(NV - 1)) begin
                    state_nxt = SCALE;
                end else begin
                    idx_nxt   = idx + IW'(1);
                    ready_nxt = NV'(1) << idx_nxt;
                end
            end
            SCALE: begin
                scaled_nxt = 8'(prod >>> 8);
                state_nxt  = SLEW;
            end
            SLEW: begin
                if (diff > STEP) begin
                    dac_nxt = dac_code + 8'(RAMP_STEP);
                end else if (diff < -STEP) begin
                    dac_nxt = dac_code - 8'(RAMP_STEP);
                end else begin
                    dac_nxt = target;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // A new underrun wins over a simultaneous clear.
        underrun_nxt = (underrun_clr ? '0 : underrun) | set_mask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            div_cnt     <= '0;
            idx         <= '0;
            acc         <= '0;
            scaled      <= '0;
            dac_code    <= 8'd128;
            voice_ready <= '0;
            sample_tick <= 1'b0;
            underrun    <= '0;
        end else begin
            state       <= state_nxt;
            div_cnt     <= (div_cnt == DW'(CLK_DIV - 1)) ? '0 : div_cnt + DW'(1);
            idx         <= idx_nxt;
            acc         <= acc_nxt;
            scaled      <= scaled_nxt;
            dac_code    <= dac_nxt;
            voice_ready <= ready_nxt;
            sample_tick <= tick_nxt;
            underrun    <= underrun_nxt;
        end
    end

endmodule

// File: tb/tb_ds8dac_mix_sched.sv
// Directed bench for ds8dac_mix_sched with NUM_VOICES=4, CLK_DIV=16, RAMP_STEP=8.
module tb_ds8dac_mix_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  voice_valid;
    logic [31:0] voice_data;
    logic [3:0]  voice_ready;
    logic [7:0]  master_vol;
    logic        enable;
    logic        underrun_clr;
    logic [7:0]  dac_code;
    logic        sample_tick;
    logic [3:0]  underrun;

    int errors = 0;
    int checks = 0;

    ds8dac_mix_sched #(
        .NUM_VOICES(4),
        .CLK_DIV   (16),
        .RAMP_STEP (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .voice_valid (voice_valid),
        .voice_data  (voice_data),
        .voice_ready (voice_ready),
        .master_vol  (master_vol),
        .enable      (enable),
        .underrun_clr(underrun_clr),
        .dac_code    (dac_code),
        .sample_tick (sample_tick),
        .underrun    (underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_voices(input logic [7:0] v0, input logic [7:0] v1,
                              input logic [7:0] v2, input logic [7:0] v3);
        voice_data = {v3, v2, v1, v0};
    endtask

    // Advance to just after the next period-start edge.
    task automatic wait_tick();
        int n = 0;
        do begin
            tick();
            n++;
        end while (!sample_tick && n < 40);
        if (!sample_tick) begin
            checks++;
            errors++;
            $display("FAIL wait_tick: sample_tick=%0b after %0d cycles, required 1", sample_tick, n);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_ready [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (dac_code !== 8'd128 || voice_ready !== 4'b0000 || sample_tick !== 1'b0 || underrun !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state: dac=%0d ready=%b tick=%b underrun=%b, required 128 0000 0 0000",
                     dac_code, voice_ready, sample_tick, underrun);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (sample_tick !== 1'b1) begin
            errors++;
            $display("FAIL first_tick: sample_tick=%b, required 1", sample_tick);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            checks++;
            if (voice_ready !== exp_ready[i]) begin
                errors++;
                $display("FAIL ready_seq[%0d]: voice_ready=%b, required %b", i, voice_ready, exp_ready[i]);
            end
        end
    endtask

    task automatic test_period();
        int n = 0;
        wait_tick();
        do begin
            tick();
            n++;
        end while (!sample_tick && n < 40);
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL period_len: %0d cycles between ticks, required 16", n);
        end
        repeat (6) tick();
        checks++;
        if (dac_code !== 8'd128) begin
            errors++;
            $display("FAIL silent_mix: dac=%0d, required 128", dac_code);
        end
    endtask

    task automatic test_ramp_up();
        int exp_dac [9] = '{136, 144, 152, 160, 168, 176, 184, 191, 191};
        set_voices(8'h40, 8'h40, 8'h40, 8'h40);
        for (int i = 0; i < 9; i++) begin
            wait_tick();
            repeat (6) tick();
            checks++;
            if (dac_code !== 8'(exp_dac[i])) begin
                errors++;
                $display("FAIL ramp_up[%0d]: dac=%0d, required %0d", i, dac_code, exp_dac[i]);
            end
        end
    endtask

    task automatic test_mixed_sign();
        int exp_dac [9] = '{183, 175, 167, 159, 151, 143, 135, 127, 127};
        set_voices(8'd127, 8'd127, 8'h80, 8'h80);
        for (int i = 0; i < 9; i++) begin
            wait_tick();
            repeat (6) tick();
            checks++;
            if (dac_code !== 8'(exp_dac[i])) begin
                errors++;
                $display("FAIL mixed_sign[%0d]: dac=%0d, required %0d", i, dac_code, exp_dac[i]);
            end
        end
    endtask

    task automatic test_underrun();
        // 8+8+0+0 with voice 2 (100) missing -> avg 4, scaled 3, target 131.
        set_voices(8'd8, 8'd8, 8'd100, 8'd0);
        voice_valid = 4'b1011;
        wait_tick();
        repeat (2) tick();
        checks++;
        if (voice_ready !== 4'b0100 || underrun !== 4'b0000) begin
            errors++;
            $display("FAIL underrun_poll: ready=%b underrun=%b, required 0100 0000", voice_ready, underrun);
        end
        tick();
        checks++;
        if (underrun !== 4'b0100) begin
            errors++;
            $display("FAIL underrun_set: underrun=%b, required 0100", underrun);
        end
        repeat (3) tick();
        checks++;
        if (dac_code !== 8'd131) begin
            errors++;
            $display("FAIL underrun_mix: dac=%0d, required 131", dac_code);
        end
        wait_tick();
        repeat (2) tick();
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 4'b0100) begin
            errors++;
            $display("FAIL underrun_set_wins: underrun=%b, required 0100", underrun);
        end
        repeat (3) tick();
        voice_valid = 4'b1111;
        underrun_clr = 1'b1;
        tick();
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 4'b0000 || dac_code !== 8'd131) begin
            errors++;
            $display("FAIL underrun_clear: underrun=%b dac=%0d, required 0000 131", underrun, dac_code);
        end
    endtask

    task automatic test_mute();
        int exp_mute [9] = '{183, 175, 167, 159, 151, 143, 135, 128, 128};
        int exp_back [2] = '{136, 144};
        set_voices(8'h40, 8'h40, 8'h40, 8'h40);
        repeat (9) begin
            wait_tick();
            repeat (6) tick();
        end
        checks++;
        if (dac_code !== 8'd191) begin
            errors++;
            $display("FAIL mute_pre: dac=%0d, required 191", dac_code);
        end
        enable = 1'b0;
        for (int i = 0; i < 9; i++) begin
            wait_tick();
            repeat (6) tick();
            checks++;
            if (dac_code !== 8'(exp_mute[i])) begin
                errors++;
                $display("FAIL mute_ramp[%0d]: dac=%0d, required %0d", i, dac_code, exp_mute[i]);
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wait_tick();
            repeat (6) tick();
            checks++;
            if (dac_code !== 8'(exp_back[i])) begin
                errors++;
                $display("FAIL unmute_ramp[%0d]: dac=%0d, required %0d", i, dac_code, exp_back[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        wait_tick();
        repeat (2) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (voice_ready !== 4'b0000 || dac_code !== 8'd128 || sample_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: ready=%b dac=%0d tick=%b, required 0000 128 0",
                     voice_ready, dac_code, sample_tick);
        end
        // 4+4+4+4 -> avg 4, scaled 3, target 131, within one step of 128.
        set_voices(8'd4, 8'd4, 8'd4, 8'd4);
        rst = 1'b0;
        tick();
        checks++;
        if (sample_tick !== 1'b1 || voice_ready !== 4'b0001) begin
            errors++;
            $display("FAIL restart_poll: tick=%b ready=%b, required 1 0001", sample_tick, voice_ready);
        end
        repeat (6) tick();
        checks++;
        if (dac_code !== 8'd131) begin
            errors++;
            $display("FAIL restart_mix: dac=%0d, required 131", dac_code);
        end
    endtask

    initial begin
        rst          = 1'b1;
        voice_valid  = 4'b1111;
        voice_data   = '0;
        master_vol   = 8'd255;
        enable       = 1'b1;
        underrun_clr = 1'b0;
        test_reset();
        test_period();
        test_ramp_up();
        test_mixed_sign();
        test_underrun();
        test_mute();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
